// File: rtl/div8bc2_seq_if.sv
// Handshake and operand/result bundle between the instruction decoder and the
// iterative divider.
interface div8bc2_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/div8bc2_seq.sv
// Iterative signed restoring divider, one quotient bit per clock, saturating.
// Define DIV8BC2_REMAINDER_EN to drive the remainder output; otherwise it is tied to 0.
module div8bc2_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  div8bc2_seq_if.slave  bus
);

  localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MaxPos  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic             dvd_neg_q, dvd_neg_d;
  // Dividend magnitude shifts out MSB first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] aq_q, aq_d;
  logic [WIDTH:0]   dvs_mag_q, dvs_mag_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH:0]   q_mag;
  logic [WIDTH:0]   q_sgn;
  logic             q_sat;
  logic             dvs_zero;

`ifdef DIV8BC2_REMAINDER_EN
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic [WIDTH-1:0] rem_fix;
`endif

  // Unsigned W-bit negation maps -2^(W-1) onto 2^(W-1), which is exact as a magnitude.
  assign dvd_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_abs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  assign shifted  = {rem_q, aq_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_mag_q};
  assign qbit     = ~diff[WIDTH+1];

  assign q_mag    = {1'b0, aq_q};
  assign q_sgn    = sign_q ? -q_mag : q_mag;
  // Only +2^(W-1) (from -2^(W-1) / -1) lands above the positive limit.
  assign q_sat    = ~q_sgn[WIDTH] & q_sgn[WIDTH-1];
  assign dvs_zero = (dvs_mag_q == '0);

`ifdef DIV8BC2_REMAINDER_EN
  assign rem_fix  = dvd_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    dvd_neg_d = dvd_neg_q;
    aq_d      = aq_q;
    dvs_mag_d = dvs_mag_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
`ifdef DIV8BC2_REMAINDER_EN
    dvd_d     = dvd_q;
    rem_out_d = rem_out_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StCalc;
          sign_d    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          dvd_neg_d = bus.dividend[WIDTH-1];
          aq_d      = dvd_abs;
          dvs_mag_d = {1'b0, dvs_abs};
          rem_d     = '0;
          cnt_d     = '0;
`ifdef DIV8BC2_REMAINDER_EN
          dvd_d     = bus.dividend;
`endif
        end
      end
      StCalc: begin
        rem_d = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
        aq_d  = {aq_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (dvs_zero) begin
          quo_d = dvd_neg_q ? MinNeg : MaxPos;
          ovf_d = 1'b1;
          dbz_d = 1'b1;
`ifdef DIV8BC2_REMAINDER_EN
          rem_out_d = dvd_q;
`endif
        end else begin
          quo_d = q_sat ? MaxPos : q_sgn[WIDTH-1:0];
          ovf_d = q_sat;
          dbz_d = 1'b0;
`ifdef DIV8BC2_REMAINDER_EN
          rem_out_d = rem_fix;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sign_q    <= 1'b0;
      dvd_neg_q <= 1'b0;
      aq_q      <= '0;
      dvs_mag_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIV8BC2_REMAINDER_EN
      dvd_q     <= '0;
      rem_out_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      dvd_neg_q <= dvd_neg_d;
      aq_q      <= aq_d;
      dvs_mag_q <= dvs_mag_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
`ifdef DIV8BC2_REMAINDER_EN
      dvd_q     <= dvd_d;
      rem_out_q <= rem_out_d;
`endif
    end
  end

  // The done cycle already sits in StIdle, so a start there is taken while busy still reads 1.
  assign bus.busy        = (state_q != StIdle) | done_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
`ifdef DIV8BC2_REMAINDER_EN
  assign bus.remainder   = rem_out_q;
`else
  assign bus.remainder   = '0;
`endif

endmodule

// File: tb/tb_div8bc2_seq.sv
// Directed self-checking bench for div8bc2_seq; remainder expectations follow
// DIV8BC2_REMAINDER_EN.
module tb_div8bc2_seq;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  div8bc2_seq_if #(.WIDTH(8)) bus ();

  div8bc2_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rem(input logic [7:0] r);
`ifdef DIV8BC2_REMAINDER_EN
    return r;
`else
    return (r & 8'h00);
`endif
  endfunction

  // Leaves the caller 1 time unit after the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 8'hxx;
    bus.divisor  = 8'hxx;
  endtask

  // Latency counts edges from the accept edge inclusive; 0 means done never came.
  task automatic wait_done(output int lat);
    int n;
    lat = 0;
    n   = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic eo, input logic ez);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd10);
    check({tag, "_q"},   32'(bus.quotient), 32'(eq));
    check({tag, "_r"},   32'(bus.remainder), 32'(exp_rem(er)));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  initial begin
    int lat;
    int n_done;
    int first;
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_q",    32'(bus.quotient), 32'd0);
    check("rst_r",    32'(bus.remainder), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ovf",  32'(bus.overflow), 32'd0);
    check("rst_dbz",  32'(bus.div_by_zero), 32'd0);

    // 1-4: signs, saturation, divide by zero
    do_div("p100_p7",  8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0);
    do_div("n100_p7",  8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0, 1'b0);
    do_div("p100_n7",  8'd100, 8'hF9, 8'hF2,  8'd2,  1'b0, 1'b0);
    do_div("n100_n7",  8'h9C,  8'hF9, 8'd14,  8'hFE, 1'b0, 1'b0);
    do_div("n128_n1",  8'h80,  8'hFF, 8'h7F,  8'd0,  1'b1, 1'b0);
    do_div("n128_p1",  8'h80,  8'd1,  8'h80,  8'd0,  1'b0, 1'b0);
    do_div("p5_z",     8'd5,   8'd0,  8'h7F,  8'd5,  1'b1, 1'b1);
    do_div("n5_z",     8'hFB,  8'd0,  8'h80,  8'hFB, 1'b1, 1'b1);

    // 5: start while busy is ignored
    start_op(8'd50, 8'd3);
    n_done = 0;
    first  = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 4) begin
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd9;
      end
      @(posedge clk);
      #1;
      if (e == 4) begin
        bus.start = 1'b0;
        check("busy_ign_busy", 32'(bus.busy), 32'd1);
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (first == 0) first = e + 1;
      end
    end
    check("busy_ign_ndone", 32'(n_done), 32'd1);
    check("busy_ign_lat",   32'(first), 32'd10);
    check("busy_ign_q",     32'(bus.quotient), 32'd16);
    check("busy_ign_r",     32'(bus.remainder), 32'(exp_rem(8'd2)));

    // start issued in the done cycle is accepted; old result holds meanwhile
    do_div("p20_p4", 8'd20, 8'd4, 8'd5, 8'd0, 1'b0, 1'b0);
    start_op(8'd77, 8'd5);
    check("b2b_busy",  32'(bus.busy), 32'd1);
    check("b2b_done",  32'(bus.done), 32'd0);
    check("b2b_hold",  32'(bus.quotient), 32'd5);
    wait_done(lat);
    check("b2b_lat",   32'(lat), 32'd10);
    check("b2b_q",     32'(bus.quotient), 32'd15);
    check("b2b_r",     32'(bus.remainder), 32'(exp_rem(8'd2)));

    // 6: reset mid-operation
    start_op(8'd77, 8'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_q",    32'(bus.quotient), 32'd0);
    check("midrst_r",    32'(bus.remainder), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_ovf",  32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n_done++;
    end
    check("midrst_nodone", 32'(n_done), 32'd0);
    do_div("p77_p5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
